// File: rtl/fence_t_uarch_ctrl_pkg.sv
// Shared types and helpers for the fence.t micro-architectural reset controller.
// Latency: n/a (types only). Backpressure: n/a.
package fence_t_uarch_ctrl_pkg;

    localparam int unsigned VLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT,
        RST_UARCH
    } fence_t_state_e;

    // Width of an index/counter covering n values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fence_t_uarch_ctrl_counter.sv
// Loadable up/down counter; load has priority over the count enable.
// Latency: new value visible one cycle after load/enable. Backpressure: none.
module fence_t_uarch_ctrl_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = down_i ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/fence_t_uarch_ctrl.sv
// fence.t sequencer: per-channel flush handshake, pad to timing event, timed uarch clear.
// Latency: flush_req one cycle after fence_t_i; outputs registered. Backpressure: halts commit while busy.
// Optional ceiling capture (ceil_o/ceil_valid_o) enabled by FENCE_T_CEIL_EN.
module fence_t_uarch_ctrl
    import fence_t_uarch_ctrl_pkg::*;
#(
    parameter int unsigned NrChannels     = 2,
    parameter int unsigned NrPadSrc       = 2,
    parameter int unsigned CntWidth       = 32,
    parameter int unsigned ClrCycles      = 16,
    parameter int unsigned InitHoldCycles = 3,
    parameter int unsigned AddrWidth      = VLEN
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fence_t_i,
    input  logic [AddrWidth-1:0]           pc_commit_i,
    input  logic [AddrWidth-1:0]           boot_addr_i,
    output logic [AddrWidth-1:0]           rst_addr_o,
    output logic [NrChannels-1:0]          flush_req_o,
    input  logic [NrChannels-1:0]          flush_ack_i,
    input  logic [NrChannels-1:0]          busy_i,
    input  logic [CntWidth-1:0]            pad_i,
    input  logic [idx_width(NrPadSrc)-1:0] pad_src_sel_i,
    input  logic [NrPadSrc-1:0]            pad_evt_i,
    output logic                           halt_o,
    output logic                           uarch_clr_o,
    output logic                           init_hold_o,
    output logic [CntWidth-1:0]            ceil_o,
    output logic                           ceil_valid_o,
    output logic                           done_o
);

    localparam int unsigned SelW  = idx_width(NrPadSrc);
    localparam int unsigned ClrW  = idx_width(ClrCycles);
    localparam int unsigned HoldW = InitHoldCycles + 1;
    localparam logic [ClrW-1:0] ClrLast = ClrW'(ClrCycles - 1);

    fence_t_state_e         state_q, state_d;
    logic [NrChannels-1:0]  ack_q, ack_d;
    logic [ClrW-1:0]        clr_cnt_q, clr_cnt_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic [AddrWidth-1:0]   rst_addr_q, rst_addr_d;
    logic [NrPadSrc-1:0]    evt_q, evt_d;

    logic [CntWidth-1:0]    pad_cnt;
    logic [SelW-1:0]        sel_eff;
    logic                   pad_load;
    logic                   all_acked;

    // Pad trigger: edge detect on every source, then pick the selected one.
    assign evt_d   = pad_evt_i;
    assign sel_eff = (32'(pad_src_sel_i) < NrPadSrc) ? pad_src_sel_i : '0;

    always_comb begin
        pad_load = 1'b0;
        for (int i = 0; i < NrPadSrc; i++) begin
            if (sel_eff == SelW'(i)) begin
                pad_load = pad_evt_i[i] & ~evt_q[i];
            end
        end
    end

    fence_t_uarch_ctrl_counter #(
        .WIDTH (CntWidth)
    ) i_pad_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (|pad_cnt),
        .load_i (pad_load),
        .down_i (1'b1),
        .d_i    (pad_i),
        .q_o    (pad_cnt)
    );

    assign all_acked = &(ack_q | flush_ack_i);

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        clr_cnt_d  = clr_cnt_q;
        rst_addr_d = rst_addr_q;
        unique case (state_q)
            IDLE: begin
                if (fence_t_i) begin
                    state_d    = FLUSH;
                    rst_addr_d = pc_commit_i + AddrWidth'(4);
                end
            end
            FLUSH: begin
                ack_d = ack_q | flush_ack_i;
                if (all_acked) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if ((busy_i == '0) && (pad_cnt == '0)) begin
                    state_d = RST_UARCH;
                    ack_d   = '0;
                end
            end
            RST_UARCH: begin
                if (clr_cnt_q == ClrLast) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ClrW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Refilled while clearing; the trailing ones give the post-clear hold window.
    assign hold_d = (state_d == RST_UARCH) ? '1 : (hold_q << 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            clr_cnt_q  <= '0;
            hold_q     <= '0;
            rst_addr_q <= boot_addr_i;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            clr_cnt_q  <= clr_cnt_d;
            hold_q     <= hold_d;
            rst_addr_q <= rst_addr_d;
            evt_q      <= evt_d;
        end
    end

    assign rst_addr_o  = rst_addr_q;
    assign flush_req_o = (state_q == FLUSH) ? ~ack_q : '0;
    assign halt_o      = (state_q != IDLE);
    assign uarch_clr_o = (state_q == RST_UARCH);
    assign done_o      = (state_q == RST_UARCH) && (clr_cnt_q == ClrLast);
    assign init_hold_o = |hold_q;

`ifdef FENCE_T_CEIL_EN
    logic [CntWidth-1:0] ceil_q, ceil_d;
    logic                ceil_valid_q, ceil_valid_d;
    logic                flush_done;

    // Ceiling = pad cycles already elapsed when the last ack lands.
    assign flush_done   = (state_q == FLUSH) && all_acked;
    assign ceil_valid_d = flush_done;

    always_comb begin
        ceil_d = ceil_q;
        if (flush_done) begin
            ceil_d = (pad_cnt == '0) ? '0 : (pad_i - pad_cnt);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ceil_q       <= '0;
            ceil_valid_q <= 1'b0;
        end else begin
            ceil_q       <= ceil_d;
            ceil_valid_q <= ceil_valid_d;
        end
    end

    assign ceil_o       = ceil_q;
    assign ceil_valid_o = ceil_valid_q;
`else
    assign ceil_o       = '0;
    assign ceil_valid_o = 1'b0;
`endif

endmodule

// File: doc/fence_t_uarch_ctrl.md
# fence_t_uarch_ctrl

Parametrised micro-architectural reset controller for the `fence.t` temporal-fence sequence. It serves an arbitrary number of flushable structures (caches, predictors, TLBs), each with its own flush request/acknowledge pair. It pads the end of the sequence to a selectable timing event and then drives a configurable-length clear of all micro-architectural state. It sits next to the flush controller in the core, takes the `fence.t` request from commit, halts commit while active, and supplies the restart PC to the PC generator.

## Interface
- `NrChannels`, 2: number of flush request/ack channels (≥1).
- `NrPadSrc`, 2: number of pad-trigger event sources (≥1).
- `CntWidth`, 32: pad counter and ceiling width.
- `ClrCycles`, 16: cycles `uarch_clr_o` stays high (≥1).
- `InitHoldCycles`, 3: extra cycles `init_hold_o` stays high after the clear ends.
- `AddrWidth`, riscv::VLEN: PC width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `fence_t_i` in 1: fence.t request pulse from commit.
- `pc_commit_i` in AddrWidth: PC of the committing fence.t.
- `boot_addr_i` in AddrWidth: reset value of the restart address.
- `rst_addr_o` out AddrWidth: PC to fetch from after the clear.
- `flush_req_o` out NrChannels: per-channel flush request.
- `flush_ack_i` in NrChannels: per-channel flush acknowledge, 1-cycle pulse.
- `busy_i` in NrChannels: channel has outstanding external handshakes.
- `pad_i` in CntWidth: pad cycle count (CSR).
- `pad_src_sel_i` in max(1,$clog2(NrPadSrc)): selects the pad-trigger source.
- `pad_evt_i` in NrPadSrc: level event sources; the rising edge triggers.
- `halt_o` out 1: halt commit.
- `uarch_clr_o` out 1: micro-architectural clear.
- `init_hold_o` out 1: suppress cache init.
- `ceil_o` out CntWidth: measured pad ceiling.
- `ceil_valid_o` out 1: ceiling captured this cycle.
- `done_o` out 1: sequence complete, 1-cycle pulse.

## Operation
States are IDLE, FLUSH, WAIT and RST_UARCH.

- **IDLE:**
  - On `fence_t_i`: go to FLUSH and capture `rst_addr_q <= pc_commit_i + 4`.
  - `fence_t_i` in any other state is ignored.
- **FLUSH:**
  - `flush_req_o[i]` is high until channel i is acknowledged.
  - Acks are latched in an `ack_q` bitmap; the corresponding request drops the cycle after its ack.
  - Repeat acks are ignored.
  - When `ack_q | flush_ack_i` is all ones: go to WAIT, pulse `ceil_valid_o`, and set `ceil_o = (pad_cnt==0) ? 0 : pad_i - pad_cnt` (modulo 2^CntWidth).
- **WAIT:**
  - When `busy_i == 0` and `pad_cnt == 0`: go to RST_UARCH and clear `ack_q`.
- **RST_UARCH:**
  - `uarch_clr_o` is high.
  - The clear counter counts 0..ClrCycles-1.
  - On the last cycle: go to IDLE, pulse `done_o`, reset the counter to 0.
- **halt_o** is `(state != IDLE)`.
- **init_hold_o** is high from the first RST_UARCH cycle through InitHoldCycles cycles after the last one. It is implemented as a shift register set each RST_UARCH cycle; `init_hold_o` is the OR of its bits.
- **Pad counter:**
  - Loads `pad_i` on a rising edge of `pad_evt_i[pad_src_sel_i]`; the edge register is per source.
  - Otherwise it decrements while nonzero and holds at 0.
  - Load wins over decrement.
  - It runs in every state, independent of the FSM.
  - A `pad_src_sel_i` out of range selects source 0.
- `uarch_clr_o` does not clear this block's own state.

## Timing
- Reset values:
  - state IDLE, all counters 0, `ack_q` 0.
  - `rst_addr_o = boot_addr_i`.
  - `flush_req_o`, `halt_o`, `uarch_clr_o`, `init_hold_o`, `ceil_o`, `ceil_valid_o`, `done_o` all 0.
- Reset mid-sequence: all outputs return to reset values the cycle after `rst_i`.
- All outputs are decoded from registers, except `ceil_o`/`ceil_valid_o`, which are registered one cycle after the FLUSH→WAIT transition.
- `flush_req_o` rises the cycle after `fence_t_i`.
- An ack arriving in the first FLUSH cycle is accepted.
- Minimum sequence (acks immediate, no pad, not busy):
  - `fence_t_i` at cycle 0: FLUSH 1, WAIT 2, RST_UARCH 3..2+ClrCycles.
  - `done_o` at 2+ClrCycles, IDLE at 3+ClrCycles.

## Configuration
- Macro `FENCE_T_CEIL_EN`:
  - Defined: ceiling capture register is present and `ceil_o`/`ceil_valid_o` behave as above.
  - Undefined: the register is removed and both outputs are tied 0.
- The FSM is identical either way.

## Structure
- `fence_t_state_e` (IDLE, FLUSH, WAIT, RST_UARCH) goes in ariane_pkg.
- The pad countdown reuses the shared `counter` sub-module: WIDTH=CntWidth, down, load, enable `|pad_cnt`.
- The FSM, ack bitmap, clear counter and init shift register live in this module.

## Test plan
- NrChannels=3, acks at +2/+5/+1 cycles, `busy_i=0`, no pad → each `flush_req_o[i]` drops the cycle after its ack; WAIT one cycle; `uarch_clr_o` high exactly 16 cycles; `done_o` one pulse.
- `pc_commit_i=0x8000_1000` → `rst_addr_o=0x8000_1004` from the cycle after `fence_t_i`; `rst_i` → `0x8000_0000` (`boot_addr_i`).
- `pad_i=100`, source 1 selected, edge on `pad_evt_i[1]` 30 cycles before last ack → `ceil_o=30`, `ceil_valid_o` pulses; RST_UARCH starts 70 cycles later.
- `busy_i[1]` held high 10 cycles into WAIT → RST_UARCH begins the cycle after it falls.
- Second `fence_t_i` during RST_UARCH → ignored, `rst_addr_o` unchanged; `init_hold_o` stays high 3 cycles after `uarch_clr_o` falls.
- `rst_i` asserted in FLUSH with 1 of 2 acks latched → next cycle IDLE, `flush_req_o=0`, `halt_o=0`; a fresh `fence_t_i` re-requests both channels.
